// File: rtl/stopwatch_counter_if.sv
// stopwatch_counter_if
//
// Bundles the signals between the stopwatch counter and its neighbours.
// The master side (divider, buttons and switches, or a testbench) drives
// the tick and control inputs. It receives the BCD digits and status.
//
// Signals
//   tick_1hz   1 Hz square wave; each rising edge is one count event
//   tick_2hz   2 Hz square wave; each rising edge is one adjust event,
//              and its level drives blinking
//   pause_btn  debounced button level; each rising edge toggles run/pause
//   adj        adjust switch level, high selects adjust mode
//   sel        adjust field select, 0 = minutes, 1 = seconds
//   min_tens   BCD minutes tens digit, 0-5
//   min_ones   BCD minutes ones digit, 0-9
//   sec_tens   BCD seconds tens digit, 0-5
//   sec_ones   BCD seconds ones digit, 0-9
//   running    high while the stopwatch is counting
//   wrap       one-cycle pulse on the 59:59 -> 00:00 rollover
//   blank_min  blank the minute digits while high
//   blank_sec  blank the second digits while high
interface stopwatch_counter_if;
    logic       tick_1hz;
    logic       tick_2hz;
    logic       pause_btn;
    logic       adj;
    logic       sel;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       wrap;
    logic       blank_min;
    logic       blank_sec;

    modport master (
        output tick_1hz,
        output tick_2hz,
        output pause_btn,
        output adj,
        output sel,
        input  min_tens,
        input  min_ones,
        input  sec_tens,
        input  sec_ones,
        input  running,
        input  wrap,
        input  blank_min,
        input  blank_sec
    );

    modport slave (
        input  tick_1hz,
        input  tick_2hz,
        input  pause_btn,
        input  adj,
        input  sel,
        output min_tens,
        output min_ones,
        output sec_tens,
        output sec_ones,
        output running,
        output wrap,
        output blank_min,
        output blank_sec
    );
endinterface

// File: rtl/stopwatch_counter.sv
// stopwatch_counter
//
// BCD minutes:seconds stopwatch (00:00 to 59:59) that sits between the
// clock divider and the seven-segment display driver. It counts on the
// 1 Hz tick in RUN, holds in PAUSED, and in ADJUST steps the selected field
// on each 2 Hz tick while that field blinks.
//
// Parameters
//   SYNC_STAGES  synchronizer depth on every asynchronous/slow input (>= 2)
//
// Ports
//   clk   100 MHz master clock
//   rst   asynchronous, active-high reset
//   bus   stopwatch_counter_if.slave; it carries the tick/button/switch
//         inputs and the digit, status and blanking outputs
module stopwatch_counter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    stopwatch_counter_if.slave bus
);

    localparam int NUM_IN = 5;

    // Bit positions of the inputs within the synchronizer vectors.
    localparam int I_1HZ   = 0;
    localparam int I_2HZ   = 1;
    localparam int I_PAUSE = 2;
    localparam int I_ADJ   = 3;
    localparam int I_SEL   = 4;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_ADJUST = 2'd2
    } state_t;

    logic [NUM_IN-1:0] raw_in;
    logic [NUM_IN-1:0] sync_pipe [SYNC_STAGES];
    logic [NUM_IN-1:0] synced;

    logic [2:0] hist;
    logic       edge_1hz;
    logic       edge_2hz;
    logic       edge_pause;

    logic adj_s;
    logic sel_s;
    logic t2_s;

    state_t     state;
    logic       resume;
    logic [3:0] min_tens_q;
    logic [3:0] min_ones_q;
    logic [3:0] sec_tens_q;
    logic [3:0] sec_ones_q;
    logic       running_q;
    logic       wrap_q;
    logic       blank_min_q;
    logic       blank_sec_q;

    logic [7:0] sec_field;
    logic [7:0] min_field;
    logic [7:0] sec_inc;
    logic [7:0] min_inc;
    logic       sec_carry;
    logic       min_carry;
    logic       adj_blank_min;
    logic       adj_blank_sec;

    // Steps a two-digit BCD field through 00..59 and back to 00.
    function automatic logic [7:0] bcd_inc59(input logic [7:0] f);
        logic [7:0] r;
        if (f[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (f[7:4] == 4'd5) ? 4'd0 : f[7:4] + 4'd1;
        end else begin
            r[3:0] = f[3:0] + 4'd1;
            r[7:4] = f[7:4];
        end
        return r;
    endfunction

    assign raw_in = {bus.sel, bus.adj, bus.pause_btn, bus.tick_2hz, bus.tick_1hz};

    // Plain shift-register synchronizer, one lane per input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_pipe[i] <= '0;
            end
        end else begin
            sync_pipe[0] <= raw_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_pipe[i] <= sync_pipe[i-1];
            end
        end
    end

    assign synced = sync_pipe[SYNC_STAGES-1];
    assign adj_s  = synced[I_ADJ];
    assign sel_s  = synced[I_SEL];
    assign t2_s   = synced[I_2HZ];

    // The edge pulses are registered so that each one is a single clean
    // cycle. Any edge the FSM does not act on in that cycle is dropped,
    // not queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist       <= '0;
            edge_1hz   <= 1'b0;
            edge_2hz   <= 1'b0;
            edge_pause <= 1'b0;
        end else begin
            hist       <= synced[2:0];
            edge_1hz   <= synced[I_1HZ]   & ~hist[I_1HZ];
            edge_2hz   <= synced[I_2HZ]   & ~hist[I_2HZ];
            edge_pause <= synced[I_PAUSE] & ~hist[I_PAUSE];
        end
    end

    assign sec_field = {sec_tens_q, sec_ones_q};
    assign min_field = {min_tens_q, min_ones_q};
    assign sec_inc   = bcd_inc59(sec_field);
    assign min_inc   = bcd_inc59(min_field);
    assign sec_carry = (sec_field == 8'h59);
    assign min_carry = (min_field == 8'h59);

    // The selected field blinks in antiphase to the 2 Hz square wave.
    assign adj_blank_min = ~sel_s & ~t2_s;
    assign adj_blank_sec =  sel_s & ~t2_s;

    // Mode FSM and BCD datapath. resume = 0 returns to RUN after ADJUST and
    // resume = 1 returns to PAUSED. The adj level takes priority over tick
    // and pause edges that land in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_RUN;
            resume      <= 1'b0;
            min_tens_q  <= 4'd0;
            min_ones_q  <= 4'd0;
            sec_tens_q  <= 4'd0;
            sec_ones_q  <= 4'd0;
            running_q   <= 1'b1;
            wrap_q      <= 1'b0;
            blank_min_q <= 1'b0;
            blank_sec_q <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (adj_s) begin
                        state       <= ST_ADJUST;
                        resume      <= 1'b0;
                        running_q   <= 1'b0;
                        blank_min_q <= adj_blank_min;
                        blank_sec_q <= adj_blank_sec;
                    end else begin
                        if (edge_1hz) begin
                            {sec_tens_q, sec_ones_q} <= sec_inc;
                            if (sec_carry) begin
                                {min_tens_q, min_ones_q} <= min_inc;
                            end
                            wrap_q <= sec_carry & min_carry;
                        end
                        if (edge_pause) begin
                            state     <= ST_PAUSED;
                            running_q <= 1'b0;
                        end
                    end
                end

                ST_PAUSED: begin
                    if (adj_s) begin
                        state       <= ST_ADJUST;
                        resume      <= 1'b1;
                        blank_min_q <= adj_blank_min;
                        blank_sec_q <= adj_blank_sec;
                    end else if (edge_pause) begin
                        state     <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end

                ST_ADJUST: begin
                    if (!adj_s) begin
                        state       <= resume ? ST_PAUSED : ST_RUN;
                        running_q   <= ~resume;
                        blank_min_q <= 1'b0;
                        blank_sec_q <= 1'b0;
                    end else begin
                        if (edge_2hz) begin
                            if (sel_s) begin
                                {sec_tens_q, sec_ones_q} <= sec_inc;
                            end else begin
                                {min_tens_q, min_ones_q} <= min_inc;
                            end
                        end
                        blank_min_q <= adj_blank_min;
                        blank_sec_q <= adj_blank_sec;
                    end
                end

                default: begin
                    state       <= ST_RUN;
                    running_q   <= 1'b1;
                    blank_min_q <= 1'b0;
                    blank_sec_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.min_tens  = min_tens_q;
    assign bus.min_ones  = min_ones_q;
    assign bus.sec_tens  = sec_tens_q;
    assign bus.sec_ones  = sec_ones_q;
    assign bus.running   = running_q;
    assign bus.wrap      = wrap_q;
    assign bus.blank_min = blank_min_q;
    assign bus.blank_sec = blank_sec_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter
//
// Drives tick, pause and adjust activity into stopwatch_counter. Each
// stimulus pushes the output snapshot it should produce, and the cycle at
// which it should appear, into a queue. A monitor pops an entry whenever
// the outputs change and compares the two.
module tb_stopwatch_counter;

    localparam int S   = 2;
    localparam int GAP = 10;

    localparam int M_RUN    = 0;
    localparam int M_PAUSED = 1;
    localparam int M_ADJ    = 2;

    localparam int OP_TICK1       = 0;
    localparam int OP_PAUSE       = 1;
    localparam int OP_BOTH        = 2;
    localparam int OP_ADJ_ON      = 3;
    localparam int OP_ADJ_OFF     = 4;
    localparam int OP_SEL         = 5;
    localparam int OP_TICK2       = 6;
    localparam int OP_ADJ_TICK    = 7;
    localparam int OP_UNADJ_TICK2 = 8;

    typedef struct {
        int   cyc;
        int   mm;
        int   ss;
        logic running;
        logic wrap;
        logic bmin;
        logic bsec;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    exp_t exp_q[$];
    exp_t last_exp;

    int   m_min;
    int   m_sec;
    int   m_mode;
    int   m_resume;
    logic m_sel;

    logic [19:0] prev_snap;
    logic [19:0] cur_snap;

    stopwatch_counter_if bus ();

    stopwatch_counter #(.SYNC_STAGES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic void model_reset();
        m_min            = 0;
        m_sec            = 0;
        m_mode           = M_RUN;
        m_resume         = M_RUN;
        last_exp.cyc     = 0;
        last_exp.mm      = 0;
        last_exp.ss      = 0;
        last_exp.running = 1'b1;
        last_exp.wrap    = 1'b0;
        last_exp.bmin    = 1'b0;
        last_exp.bsec    = 1'b0;
    endfunction

    // One second of stopwatch time; returns 1 on the rollover to 00:00.
    function automatic logic model_count();
        m_sec++;
        if (m_sec == 60) begin
            m_sec = 0;
            m_min = (m_min + 1) % 60;
        end
        return (m_min == 0 && m_sec == 0);
    endfunction

    // Records the visible state of the model, as it stands, for cycle 'at'.
    // t2 is the tick_2hz level then in force. A snapshot equal to the last
    // one is not a visible change and is not queued.
    function automatic void push_exp(input int at, input logic w, input logic t2);
        exp_t e;
        e.cyc     = at;
        e.mm      = m_min;
        e.ss      = m_sec;
        e.running = (m_mode == M_RUN);
        e.wrap    = w;
        e.bmin    = (m_mode == M_ADJ) && !m_sel && !t2;
        e.bsec    = (m_mode == M_ADJ) &&  m_sel && !t2;
        if (e.mm != last_exp.mm || e.ss != last_exp.ss || e.running != last_exp.running ||
            e.wrap != last_exp.wrap || e.bmin != last_exp.bmin || e.bsec != last_exp.bsec) begin
            exp_q.push_back(e);
            last_exp = e;
        end
    endfunction

    function automatic void enter_adjust(input logic s);
        m_sel = s;
        if (m_mode != M_ADJ) begin
            m_resume = m_mode;
            m_mode   = M_ADJ;
        end
    endfunction

    // Issues one operation starting at a falling clock edge.
    task automatic apply_stimulus(input int op, input logic arg);
        int   d;
        logic w;
        d = cyc;
        case (op)
            OP_TICK1: begin
                bus.tick_1hz = 1'b1;
                if (m_mode == M_RUN) begin
                    w = model_count();
                    push_exp(d + S + 2, w, 1'b0);
                    if (w) push_exp(d + S + 3, 1'b0, 1'b0);
                end
                step(2);
                bus.tick_1hz = 1'b0;
                step(GAP - 2);
            end
            OP_PAUSE: begin
                bus.pause_btn = 1'b1;
                if (m_mode == M_RUN) begin
                    m_mode = M_PAUSED;
                    push_exp(d + S + 2, 1'b0, 1'b0);
                end else if (m_mode == M_PAUSED) begin
                    m_mode = M_RUN;
                    push_exp(d + S + 2, 1'b0, 1'b0);
                end
                step(2);
                bus.pause_btn = 1'b0;
                step(GAP - 2);
            end
            OP_BOTH: begin
                bus.tick_1hz  = 1'b1;
                bus.pause_btn = 1'b1;
                if (m_mode == M_RUN) begin
                    w      = model_count();
                    m_mode = M_PAUSED;
                    push_exp(d + S + 2, w, 1'b0);
                    if (w) push_exp(d + S + 3, 1'b0, 1'b0);
                end else if (m_mode == M_PAUSED) begin
                    m_mode = M_RUN;
                    push_exp(d + S + 2, 1'b0, 1'b0);
                end
                step(2);
                bus.tick_1hz  = 1'b0;
                bus.pause_btn = 1'b0;
                step(GAP - 2);
            end
            OP_ADJ_ON: begin
                bus.sel = arg;
                bus.adj = 1'b1;
                enter_adjust(arg);
                push_exp(d + S + 1, 1'b0, 1'b0);
                step(GAP);
            end
            OP_ADJ_OFF: begin
                bus.adj = 1'b0;
                if (m_mode == M_ADJ) begin
                    m_mode = m_resume;
                    push_exp(d + S + 1, 1'b0, 1'b0);
                end
                step(GAP);
            end
            OP_SEL: begin
                bus.sel = arg;
                m_sel   = arg;
                push_exp(d + S + 1, 1'b0, 1'b0);
                step(GAP);
            end
            OP_TICK2: begin
                bus.tick_2hz = 1'b1;
                if (m_mode == M_ADJ) begin
                    push_exp(d + S + 1, 1'b0, 1'b1);
                    if (m_sel) m_sec = (m_sec + 1) % 60;
                    else       m_min = (m_min + 1) % 60;
                    push_exp(d + S + 2, 1'b0, 1'b1);
                    push_exp(d + S + 3, 1'b0, 1'b0);
                end
                step(2);
                bus.tick_2hz = 1'b0;
                step(GAP - 2);
            end
            OP_ADJ_TICK: begin
                bus.tick_1hz = 1'b1;
                step(1);
                bus.sel = arg;
                bus.adj = 1'b1;
                enter_adjust(arg);
                push_exp(d + S + 2, 1'b0, 1'b0);
                step(1);
                bus.tick_1hz = 1'b0;
                step(GAP - 2);
            end
            OP_UNADJ_TICK2: begin
                bus.tick_2hz = 1'b1;
                push_exp(d + S + 1, 1'b0, 1'b1);
                step(1);
                bus.adj = 1'b0;
                if (m_mode == M_ADJ) begin
                    m_mode = m_resume;
                    push_exp(d + S + 2, 1'b0, 1'b1);
                end
                step(1);
                bus.tick_2hz = 1'b0;
                step(GAP - 2);
            end
            default: step(GAP);
        endcase
    endtask

    task automatic repeat_op(input int op, input logic arg, input int n);
        for (int k = 0; k < n; k++) apply_stimulus(op, arg);
    endtask

    function automatic int digits_now();
        return {16'h0, bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
    endfunction

    // Asserts rst between clock edges and checks that the outputs clear at once.
    task automatic reset_and_check(input string tag);
        check_output({tag, "_queue_drained"}, exp_q.size(), 0);
        #2;
        rst           = 1'b1;
        bus.tick_1hz  = 1'b0;
        bus.tick_2hz  = 1'b0;
        bus.pause_btn = 1'b0;
        bus.adj       = 1'b0;
        bus.sel       = 1'b0;
        #1;
        check_output({tag, "_digits"}, digits_now(), 0);
        check_output({tag, "_flags"}, {bus.running, bus.wrap, bus.blank_min, bus.blank_sec}, 4'b1000);
        model_reset();
        step(2);
        rst = 1'b0;
        step(3);
    endtask

    // Outputs are sampled on the falling edge. Any change must match the
    // oldest queued snapshot, including the cycle it was due.
    always @(negedge clk) begin
        exp_t e;
        cur_snap = {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones,
                    bus.running, bus.wrap, bus.blank_min, bus.blank_sec};
        if (rst) begin
            prev_snap = cur_snap;
        end else if (cur_snap !== prev_snap) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_update: got %h, expected no change (cycle %0d)", cur_snap, cyc);
            end else begin
                e = exp_q.pop_front();
                check_output("update_cycle", cyc, e.cyc);
                check_output("update_digits", {12'h0, cur_snap[19:4]},
                             {16'h0, 4'(e.mm / 10), 4'(e.mm % 10), 4'(e.ss / 10), 4'(e.ss % 10)});
                check_output("update_flags", {28'h0, cur_snap[3:0]},
                             {28'h0, e.running, e.wrap, e.bmin, e.bsec});
            end
            prev_snap = cur_snap;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.tick_1hz  = 1'b0;
        bus.tick_2hz  = 1'b0;
        bus.pause_btn = 1'b0;
        bus.adj       = 1'b0;
        bus.sel       = 1'b0;
        m_sel         = 1'b0;
        model_reset();
        step(3);
        check_output("reset_digits", digits_now(), 0);
        check_output("reset_flags", {bus.running, bus.wrap, bus.blank_min, bus.blank_sec}, 4'b1000);
        rst = 1'b0;
        step(3);

        // Basic counting.
        repeat_op(OP_TICK1, 1'b0, 5);
        check_output("count_5", digits_now(), 16'h0005);
        check_output("count_5_running", bus.running, 1);

        // Preset 59:58 through adjust, then roll over.
        apply_stimulus(OP_ADJ_ON, 1'b0);
        repeat_op(OP_TICK2, 1'b0, 59);
        apply_stimulus(OP_SEL, 1'b1);
        repeat_op(OP_TICK2, 1'b0, 53);
        apply_stimulus(OP_ADJ_OFF, 1'b0);
        check_output("preset_5958", digits_now(), 16'h5958);
        apply_stimulus(OP_TICK1, 1'b0);
        check_output("at_5959", digits_now(), 16'h5959);
        apply_stimulus(OP_TICK1, 1'b0);
        check_output("rolled_0000", digits_now(), 16'h0000);

        // Minute carry from 09:59.
        apply_stimulus(OP_ADJ_ON, 1'b0);
        repeat_op(OP_TICK2, 1'b0, 9);
        apply_stimulus(OP_SEL, 1'b1);
        repeat_op(OP_TICK2, 1'b0, 59);
        apply_stimulus(OP_ADJ_OFF, 1'b0);
        apply_stimulus(OP_TICK1, 1'b0);
        check_output("carry_1000", digits_now(), 16'h1000);

        // Pause holds the count.
        reset_and_check("reset_run");
        repeat_op(OP_TICK1, 1'b0, 10);
        apply_stimulus(OP_PAUSE, 1'b0);
        repeat_op(OP_TICK1, 1'b0, 3);
        check_output("paused_0010", digits_now(), 16'h0010);
        check_output("paused_running", bus.running, 0);
        apply_stimulus(OP_PAUSE, 1'b0);
        apply_stimulus(OP_TICK1, 1'b0);
        check_output("resumed_0011", digits_now(), 16'h0011);

        // Adjust seconds from PAUSED without minute carry.
        apply_stimulus(OP_PAUSE, 1'b0);
        apply_stimulus(OP_ADJ_ON, 1'b1);
        repeat_op(OP_TICK2, 1'b0, 47);
        apply_stimulus(OP_ADJ_OFF, 1'b0);
        check_output("adj_preset_0058", digits_now(), 16'h0058);
        apply_stimulus(OP_ADJ_ON, 1'b1);
        repeat_op(OP_TICK2, 1'b0, 3);
        check_output("adj_sec_0001", digits_now(), 16'h0001);
        check_output("adj_blanks", {bus.blank_min, bus.blank_sec}, 2'b01);
        apply_stimulus(OP_ADJ_OFF, 1'b0);
        check_output("adj_back_paused", bus.running, 0);

        // Tick and pause in the same cycle from RUN at 00:20.
        apply_stimulus(OP_PAUSE, 1'b0);
        apply_stimulus(OP_ADJ_ON, 1'b1);
        repeat_op(OP_TICK2, 1'b0, 19);
        apply_stimulus(OP_ADJ_OFF, 1'b0);
        apply_stimulus(OP_BOTH, 1'b0);
        check_output("both_0021", digits_now(), 16'h0021);
        check_output("both_running", bus.running, 0);

        // adj rising with a 1 Hz edge, and adj falling with a 2 Hz edge.
        apply_stimulus(OP_PAUSE, 1'b0);
        apply_stimulus(OP_ADJ_TICK, 1'b0);
        check_output("adj_tick_no_inc", digits_now(), 16'h0021);
        apply_stimulus(OP_UNADJ_TICK2, 1'b0);
        check_output("unadj_no_inc", digits_now(), 16'h0021);
        check_output("unadj_running", bus.running, 1);

        // Randomized mix of operations.
        for (int i = 0; i < 150; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (m_mode == M_ADJ) begin
                if      (r < 40) apply_stimulus(OP_TICK2, 1'b0);
                else if (r < 55) apply_stimulus(OP_SEL, ~m_sel);
                else if (r < 65) apply_stimulus(OP_PAUSE, 1'b0);
                else if (r < 75) apply_stimulus(OP_TICK1, 1'b0);
                else if (r < 90) apply_stimulus(OP_ADJ_OFF, 1'b0);
                else             apply_stimulus(OP_UNADJ_TICK2, 1'b0);
            end else begin
                if      (r < 45) apply_stimulus(OP_TICK1, 1'b0);
                else if (r < 60) apply_stimulus(OP_PAUSE, 1'b0);
                else if (r < 70) apply_stimulus(OP_BOTH, 1'b0);
                else if (r < 85) apply_stimulus(OP_ADJ_ON, 1'($urandom_range(0, 1)));
                else if (r < 95) apply_stimulus(OP_ADJ_TICK, 1'($urandom_range(0, 1)));
                else             apply_stimulus(OP_TICK2, 1'b0);
            end
        end

        // Reset while in ADJUST, then count again.
        if (m_mode != M_ADJ) apply_stimulus(OP_ADJ_ON, 1'($urandom_range(0, 1)));
        reset_and_check("reset_adjust");
        repeat_op(OP_TICK1, 1'b0, 2);
        check_output("after_reset_0002", digits_now(), 16'h0002);

        step(GAP);
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            failures++;
            $display("[TB] FAIL missing_update: got no change, expected %02d:%02d at cycle %0d", e.mm, e.ss, e.cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Consumes the square-wave clock outputs of the clock divider (1 Hz, 2 Hz) in the 100 MHz `clk` domain and maintains a BCD minutes:seconds count from 00:00 to 59:59. It has run, pause and adjust modes. It sits between the divider and the seven-segment display driver. It supplies four BCD digits plus per-field blanking for adjust-mode flashing.

## Interface
- `SYNC_STAGES`, default 2: number of synchronizer flops on every asynchronous or slow input. Legal values are 2 or more.
- `clk`  in  1  100 MHz master clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `tick_1hz`  in  1  1 Hz square wave from the divider. Each rising edge is one count event.
- `tick_2hz`  in  1  2 Hz square wave from the divider. Each rising edge is one adjust event. Its level drives blinking.
- `pause_btn`  in  1  debounced button level. Each rising edge toggles run/pause.
- `adj`  in  1  adjust switch level. High means adjust mode.
- `sel`  in  1  adjust field select: 0 selects minutes, 1 selects seconds.
- `min_tens`  out  4  BCD, 0–5.
- `min_ones`  out  4  BCD, 0–9.
- `sec_tens`  out  4  BCD, 0–5.
- `sec_ones`  out  4  BCD, 0–9.
- `running`  out  1  high in RUN state.
- `wrap`  out  1  one-cycle pulse when the count rolls over from 59:59 to 00:00 in RUN.
- `blank_min`  out  1  display driver blanks the minute digits while this is high.
- `blank_sec`  out  1  display driver blanks the second digits while this is high.

## Operation
- **Input conditioning.**
  - Every input except `clk` and `rst` passes through `SYNC_STAGES` flops.
  - `tick_1hz`, `tick_2hz` and `pause_btn` each get one further history flop.
  - A rising edge is detected when the synchronized value is 1 and the history value is 0.
  - `adj` and `sel` are used as synchronized levels.
- **FSM states:** RUN, PAUSED, ADJUST. A 1-bit `resume` register records the state to return to from ADJUST.
- **RUN:**
  - Each 1 Hz edge increments mm:ss as a BCD count: `sec_ones` 9→0 carries into `sec_tens`; `sec_tens` 5→0 carries into `min_ones`, and so on.
  - At 59:59 the count goes to 00:00 and `wrap` is high for exactly one cycle.
  - A pause edge moves the FSM to PAUSED.
- **PAUSED:**
  - Digits hold.
  - 1 Hz edges are ignored.
  - A pause edge moves the FSM to RUN.
- **Entering ADJUST:** synchronized `adj` = 1 in RUN or PAUSED moves the FSM to ADJUST and loads `resume` with the current state.
- **ADJUST:**
  - 1 Hz edges and pause edges are ignored; a pause edge is discarded, not queued.
  - Each 2 Hz edge increments the selected field only, with no carry between fields.
  - Seconds count 00→59→00. Minutes count 00→59→00.
  - `wrap` stays 0.
- **Leaving ADJUST:** synchronized `adj` = 0 returns the FSM to the state held in `resume`.
- **Blanking:**
  - In ADJUST, the output for the field chosen by `sel` equals the inverse of the synchronized `tick_2hz` level. The other blank output is 0.
  - Outside ADJUST, both blank outputs are 0.
- **Simultaneous events, all evaluated in the same cycle:**
  - 1 Hz edge and pause edge in RUN: the increment happens and the FSM goes to PAUSED.
  - 1 Hz edge and pause edge in PAUSED: no increment; the FSM goes to RUN.
  - `adj` rising and a 1 Hz edge in RUN: no increment; the FSM goes to ADJUST.
  - `adj` falling and a 2 Hz edge: no adjust increment; the FSM leaves ADJUST.
  - A change of `sel` takes effect on the next 2 Hz edge.
- **Reset:**
  - Asserting `rst` at any time, including mid-increment or in ADJUST, immediately forces: all digits 0, state RUN, `resume` RUN, `running` = 1, `wrap` = 0, `blank_min` = 0, `blank_sec` = 0.
  - All synchronizer and history flops reset to 0.
  - The divider shares `rst` and holds its outputs low during reset, so no spurious edge is detected after release.

## Timing
- All state changes on rising `clk`.
- **Edge latency:** an input first sampled high at clk edge N produces a digit, state or `wrap` update at edge N + `SYNC_STAGES` + 1. This is edge N+3 at the default.
- **`adj` and `sel` latency:** a level change first sampled at edge N affects the FSM at edge N + `SYNC_STAGES`.
- All outputs are registered. The blank outputs follow the synchronized `tick_2hz` plus one register.
- `running` = 1 exactly when the state is RUN.
- `wrap` is a single-cycle pulse, asserted in the same cycle as the 00:00 digits.
- Minimum edge spacing handled: one edge every `SYNC_STAGES` + 2 clk cycles on each tick input. The bench may drive ticks at that rate.

## Test plan
- **Reset and count:** release `rst`, then 5 `tick_1hz` pulses. Expect the digits to read 00:05, `running` = 1, and each update exactly 3 clk cycles after the tick rises.
- **Rollover:** from 59:58, apply 2 ticks. Expect 59:59, then 00:00 with `wrap` high for exactly 1 cycle. Expect no `wrap` at any other time.
- **Carry:** from 09:59, apply 1 tick. Expect 10:00.
- **Pause:**
  - From 00:10, a pause pulse followed by 3 ticks: digits stay 00:10 and `running` = 0.
  - A second pause pulse followed by 1 tick: expect 00:11.
- **Adjust seconds:**
  - From PAUSED at 00:58, set `adj` = 1, `sel` = 1, then 3 `tick_2hz` edges. Expect 00:01 (no minute carry).
  - `blank_sec` is the inverse of the synced 2 Hz level and `blank_min` = 0.
  - Drop `adj`: expect the FSM back in PAUSED with `running` = 0.
- **Simultaneous events and reset:**
  - In RUN at 00:20, drive a tick edge and a pause edge in the same cycle. Expect 00:21 and `running` = 0.
  - Then assert `rst` while in ADJUST. Expect 00:00, RUN, and all blank outputs and `wrap` at 0 immediately.
